// File: rtl/adder_pkg.sv
// Shared definitions for the truncated-approximate adder family.
package adder_pkg;

  typedef enum logic [1:0] {IDLE, ACC, DONE} acc_state_e;

  // Clear the low ignore_bit bits; a value carries no information below them.
  function automatic logic [63:0] approx_mask(input logic [63:0] value, input int ignore_bit);
    return value & ~((64'd1 << ignore_bit) - 64'd1);
  endfunction

  // Clamp a 64-bit signed value into the signed range of 'width' bits.
  function automatic logic [63:0] sat_clip(input logic [63:0] value, input int width);
    logic signed [63:0] v, hi, lo;
    v  = signed'(value);
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return value;
  endfunction

endpackage

// File: rtl/Adder_trua.sv
// Combinational truncated adder: operands sign-extended to WIDTH_B+1 bits,
// low IGNORE_BIT bits dropped before the add so no carry leaves that region.
module Adder_trua import adder_pkg::*; #(
  parameter int WIDTH_A    = 8,
  parameter int WIDTH_B    = 16,
  parameter int IGNORE_BIT = 2
) (
  input  logic [WIDTH_A-1:0] A,
  input  logic [WIDTH_B-1:0] B,
  input  logic               Carry,
  output logic [WIDTH_B:0]   Sum
);
  localparam int W = WIDTH_B + 1;

  logic [W-1:0] a_x, b_x;
  logic         cin;

  assign a_x = {{(W - WIDTH_A){A[WIDTH_A-1]}}, A};
  assign b_x = {B[WIDTH_B-1], B};
  // A carry-in lands in the ignored region unless nothing is ignored.
  assign cin = (IGNORE_BIT == 0) ? Carry : 1'b0;

  // Sum of the masked operands, kept to W bits (cannot overflow W).
  assign Sum = W'(approx_mask(64'(a_x), IGNORE_BIT) + approx_mask(64'(b_x), IGNORE_BIT) + 64'(cin));

endmodule

// File: rtl/acc_trua.sv
// Streaming truncated-approximate packet accumulator with valid/ready result.
module acc_trua import adder_pkg::*; #(
  parameter int IGNORE_BIT = 2,
  parameter int WIDTH_IN   = 8,
  parameter int WIDTH_ACC  = 16,
  parameter int SATURATE   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_IN-1:0]  in_data,
  input  logic                 in_last,
  input  logic                 clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH_ACC-1:0] out_data,
  output logic                 out_ovf
);
  acc_state_e           state_q, state_d;
  logic [WIDTH_ACC-1:0] acc_q, acc_d, add_b, res;
  logic [WIDTH_ACC-1:0] out_data_q, out_data_d;
  logic                 ovf_q, ovf_d, out_ovf_q, out_ovf_d;
  logic [WIDTH_ACC:0]   s;
  logic [63:0]          s_ext;
  logic                 ovf_s, accept;

  // The first operand of a packet adds to zero, not to the stale accumulator.
  assign add_b = (state_q == IDLE) ? '0 : acc_q;

  Adder_trua #(
    .WIDTH_A   (WIDTH_IN),
    .WIDTH_B   (WIDTH_ACC),
    .IGNORE_BIT(IGNORE_BIT)
  ) u_add (
    .A    (in_data),
    .B    (add_b),
    .Carry(1'b0),
    .Sum  (s)
  );

  // s has one guard bit; disagreement with the WIDTH_ACC sign bit is overflow.
  assign ovf_s = s[WIDTH_ACC] ^ s[WIDTH_ACC-1];
  assign s_ext = {{(63 - WIDTH_ACC){s[WIDTH_ACC]}}, s};
  // Re-masking after the clamp turns the positive limit into MAXQ.
  assign res   = (SATURATE != 0)
               ? WIDTH_ACC'(approx_mask(sat_clip(s_ext, WIDTH_ACC), IGNORE_BIT))
               : s[WIDTH_ACC-1:0];

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign accept    = in_valid && in_ready;

  // Next-state: clear beats everything, including a same-cycle operand.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE, ACC: begin
          if (accept) begin
            acc_d = res;
            ovf_d = ((state_q == ACC) ? ovf_q : 1'b0) | ovf_s;
            if (in_last) begin
              state_d    = DONE;
              out_data_d = res;
              out_ovf_d  = ovf_d;
            end else begin
              state_d = ACC;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_acc_trua.sv
// Directed bench for acc_trua: default instance plus two WIDTH_ACC=10 variants.
module tb_acc_trua;
  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_last, clear, out_ready;
  logic [7:0] in_data;

  logic        rdy_a, vld_a, ovf_a;
  logic [15:0] dat_a;
  logic        rdy_b, vld_b, ovf_b;
  logic [9:0]  dat_b;
  logic        rdy_c, vld_c, ovf_c;
  logic [9:0]  dat_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  acc_trua u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
    .in_last(in_last), .clear(clear), .out_valid(vld_a), .out_ready(out_ready),
    .out_data(dat_a), .out_ovf(ovf_a)
  );

  acc_trua #(.WIDTH_ACC(10), .SATURATE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
    .in_last(in_last), .clear(clear), .out_valid(vld_b), .out_ready(out_ready),
    .out_data(dat_b), .out_ovf(ovf_b)
  );

  acc_trua #(.WIDTH_ACC(10), .SATURATE(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c), .in_data(in_data),
    .in_last(in_last), .clear(clear), .out_valid(vld_c), .out_ready(out_ready),
    .out_data(dat_c), .out_ovf(ovf_c)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input bit last);
    in_valid = 1'b1;
    in_data  = 8'(d);
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; clear = 1'b0;
    out_ready = 1'b1; in_data = '0;
    #12;
    chk("rst_in_ready",  int'(rdy_a), 1);
    chk("rst_out_valid", int'(vld_a), 0);
    chk("rst_out_data",  int'($signed(dat_a)), 0);
    chk("rst_out_ovf",   int'(ovf_a), 0);
    rst_n = 1'b1;
    step();

    // 5,3 -> 4 + 0 = 4, result the cycle after the last accept
    push(5, 1'b0);
    chk("t1_no_early_valid", int'(vld_a), 0);
    push(3, 1'b1);
    chk("t1_valid",    int'(vld_a), 1);
    chk("t1_data",     int'($signed(dat_a)), 4);
    chk("t1_ovf",      int'(ovf_a), 0);
    chk("t1_not_ready", int'(rdy_a), 0);
    step();
    chk("t1_drained",  int'(vld_a), 0);
    chk("t1_ready",    int'(rdy_a), 1);

    // Negative operands: -5 -> -8, -1 -> -4, -128 stays
    push(-5, 1'b0); push(3, 1'b1);
    chk("t2_neg5_3", int'($signed(dat_a)), -8);
    step();
    push(-1, 1'b0); push(1, 1'b1);
    chk("t2_neg1_1", int'($signed(dat_a)), -4);
    step();
    push(-128, 1'b1);
    chk("t2_single_valid", int'(vld_a), 1);
    chk("t2_single", int'($signed(dat_a)), -128);
    step();

    // Five 127s (124 each) = 620: clamps / wraps in 10 bits, fits in 16
    for (int i = 0; i < 5; i++) push(127, (i == 4));
    chk("t3_sat_data", int'($signed(dat_b)), 508);
    chk("t3_sat_ovf",  int'(ovf_b), 1);
    chk("t3_wrap_data", int'($signed(dat_c)), -404);
    chk("t3_wrap_ovf",  int'(ovf_c), 1);
    chk("t3_wide_data", int'($signed(dat_a)), 620);
    chk("t3_wide_ovf",  int'(ovf_a), 0);
    step();

    // Backpressure: result held three cycles, handshake on the fourth
    out_ready = 1'b0;
    push(64, 1'b0); push(64, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_valid", int'(vld_a), 1);
      chk("t4_hold_data",  int'($signed(dat_a)), 128);
      chk("t4_hold_ready", int'(rdy_a), 0);
      if (i < 2) step();
    end
    chk("t4_ovf_cleared", int'(ovf_b), 0);
    out_ready = 1'b1;
    step();
    chk("t4_released_valid", int'(vld_a), 0);
    chk("t4_released_ready", int'(rdy_a), 1);

    // Gaps between operands
    push(8, 1'b0);
    chk("t5_gap1", int'(vld_a), 0);
    step();
    chk("t5_gap2", int'(vld_a), 0);
    step();
    chk("t5_gap3", int'(vld_a), 0);
    push(12, 1'b1);
    chk("t5_valid", int'(vld_a), 1);
    chk("t5_data",  int'($signed(dat_a)), 20);
    step();

    // Clear in ACC, with a last operand presented in the same cycle
    push(40, 1'b0); push(40, 1'b0);
    in_valid = 1'b1; in_data = 8'd40; in_last = 1'b1; clear = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0; clear = 1'b0;
    chk("t6_clr_acc_valid", int'(vld_a), 0);
    chk("t6_clr_acc_ready", int'(rdy_a), 1);
    step();
    chk("t6_clr_acc_quiet", int'(vld_a), 0);

    // Clear in DONE discards the pending result
    out_ready = 1'b0;
    push(40, 1'b1);
    chk("t6_done_valid", int'(vld_a), 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t6_clr_done_valid", int'(vld_a), 0);
    out_ready = 1'b1;
    push(4, 1'b1);
    chk("t6_after_clear", int'($signed(dat_a)), 4);
    step();

    // Reset mid-packet
    push(100, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_ready", int'(rdy_a), 1);
    chk("t6_rst_valid", int'(vld_a), 0);
    chk("t6_rst_data",  int'($signed(dat_a)), 0);
    chk("t6_rst_ovf",   int'(ovf_a), 0);
    rst_n = 1'b1;
    step();
    push(8, 1'b0); push(4, 1'b1);
    chk("t6_post_rst_valid", int'(vld_a), 1);
    chk("t6_post_rst_data",  int'($signed(dat_a)), 12);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_trua.md
Name: acc_trua

Overview:
- Streaming truncated-approximate accumulator; consumes signed operands and sums them into one packet total.
- It is the consumer end of the approximate adder path. It sits at the bottom of each systolic-array column and drains partial sums from the PEs.
- Per packet (in_last marks the end), it returns one accumulated value over a valid/ready output handshake.
- Low IGNORE_BIT bits are truncated exactly as in the approximate adder: no carry is generated from the ignored region.

Parameters:
- IGNORE_BIT, 2: number of LSBs forced to zero in operand and result; 0 gives exact addition.
- WIDTH_IN, 8: signed input operand width.
- WIDTH_ACC, 16: signed accumulator/output width; must be >= WIDTH_IN and > IGNORE_BIT.
- SATURATE, 1: 1 = clamp on overflow; 0 = two's-complement wrap.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept an operand
- in_data  input  WIDTH_IN  signed operand
- in_last  input  1  operand is the last of its packet; sampled with the in handshake
- clear  input  1  synchronous abort/flush
- out_valid  output  1  packet result valid
- out_ready  input  1  downstream accepts the result
- out_data  output  WIDTH_ACC  signed packet total, low IGNORE_BIT bits always 0
- out_ovf  output  1  sticky: at least one overflow occurred in this packet

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, acc=0, ovf=0, in_ready=1, out_valid=0, out_data=0, out_ovf=0.
- Operand path:
  - x = sign-extend(in_data) to WIDTH_ACC+1 bits, then low IGNORE_BIT bits cleared.
  - s = acc + x, where acc also has its low bits zero.
  - Overflow occurs when s is outside [-2^(WIDTH_ACC-1), 2^(WIDTH_ACC-1)-1].
- Overflow handling:
  - SATURATE=1: clamp to MAXQ = 2^(WIDTH_ACC-1)-2^IGNORE_BIT, or to MIN = -2^(WIDTH_ACC-1).
  - SATURATE=0: keep the low WIDTH_ACC bits.
  - Either mode: ovf is set and stays set until the packet completes.
- FSM states: IDLE, ACC, DONE.
  - IDLE: in_ready=1. On accept: acc <= approx(0 + x), ovf <= 0. If in_last, go to DONE; otherwise go to ACC.
  - ACC: in_ready=1. On accept: acc <= approx(acc + x). If in_last, go to DONE.
  - DONE: in_ready=0, out_valid=1, out_data=acc, out_ovf=ovf. All three are held stable until out_ready.
- DONE exit: on out_valid && out_ready, go to IDLE, acc <= 0, out_valid drops on the next cycle.
- No skid buffer, so the next packet cannot be accepted in the drain cycle.
- Latency: out_valid rises the cycle after the last operand is accepted.
- Single-operand packet: IDLE to DONE directly; result = masked x.
- Cycles in IDLE/ACC with in_valid=0 leave state unchanged, so gaps are allowed.
- clear has priority over everything, in any state:
  - next cycle: IDLE, acc=0, ovf=0, out_valid=0.
  - A pending result in DONE is discarded.
  - Operands presented in the same cycle as clear are dropped, even though in_ready=1.
- Reset mid-packet or mid-drain: immediately returns to the reset values; no partial result is emitted.
- out_data is registered. In states other than DONE it shows the last emitted value (0 after reset); it is don't-care unless out_valid.

Decomposition:
- Shared package adder_pkg contains:
  - state enum acc_state_e {IDLE, ACC, DONE};
  - function approx_mask(value, IGNORE_BIT);
  - function sat_clip(value, width), used by the other approximate adders as well.
- Sub-module: reuse the existing Adder_trua as the combinational adder.
  - Parameters: WIDTH_A=WIDTH_IN, WIDTH_B=WIDTH_ACC, IGNORE_BIT passed through, Carry tied 0.
  - The width-extension/overflow detect and the FSM stay in acc_trua.

Test Plan:
All scenarios use defaults (IGNORE_BIT=2, WIDTH_IN=8, WIDTH_ACC=16, SATURATE=1) unless stated.
1. Packet 5, 3(last), out_ready=1 -> out_valid one cycle after the last accept; out_data=4 (5→4, 3→0); out_ovf=0.
2. Packet -5, 3(last) -> out_data=-8. Packet -1, 1(last) -> out_data=-4. Single packet -128(last) -> out_data=-128.
3. WIDTH_ACC=10, five operands of 127 with the last flagged:
   - SATURATE=1 -> out_data=508 (124×5=620 clamped to MAXQ), out_ovf=1.
   - SATURATE=0 -> out_data=-404 (620 wrapped mod 1024), out_ovf=1.
4. Backpressure: packet 64, 64(last) with out_ready=0 for 3 cycles -> out_valid, out_data=128 and in_ready=0 stable for those cycles; the handshake completes on cycle 4, and in_ready=1 the following cycle.
5. Gaps: in_valid toggles 1,0,0,1 on operands 8, 12(last) -> out_data=20, with no spurious output during the gaps.
6. Abort: clear asserted in ACC after operands 40, 40, and also clear in DONE -> no out_valid; the next packet 4(last) returns 4. Then rst_n pulsed low mid-packet -> outputs return to reset values, and the next packet computes from 0.
